e_muldiv: RTL and testbench
===========================

Name: e_muldiv

Overview:
- Execute-stage multiply/divide unit. Consumes E_V1, E_V2 and E_Instr, which the D->E pipeline register produces.
- Owns the HI/LO architectural registers and runs MULT/MULTU/DIV/DIVU as multi-cycle operations.
- Exports Start/Busy to the D-stage hazard unit, which stalls any MD-class instruction while the unit is occupied.
- Serves MFHI/MFLO reads combinationally into the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, Busy duration for MULT/MULTU (>=1).
- DIV_CYCLES, 10, Busy duration for DIV/DIVU (>=1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state immediately when 0
- E_V1  in  32  rs operand (forwarded)
- E_V2  in  32  rt operand (forwarded)
- E_Instr  in  32  E-stage instruction; 0 = bubble
- E_Start  out  1  combinational; 1 when E_Instr is MULT/MULTU/DIV/DIVU and state is IDLE
- E_Busy  out  1  registered; 1 while an operation is in flight
- E_MDout  out  32  HI when E_Instr is MFHI, LO when MFLO, else 0

Behaviour:
- Decode: opcode 0 with funct MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13. Every other instruction is ignored.
- Reset (reset=0, async): state=IDLE, count=0, HI=LO=0, pending results=0, E_Busy=0. E_Start and E_MDout follow combinationally from the cleared state.
- FSM states: IDLE, BUSY.
- IDLE & E_Start:
  - At the clock edge the full result is computed from E_V1/E_V2 into pend_hi/pend_lo.
  - count loads MULT_CYCLES or DIV_CYCLES; state goes to BUSY.
- BUSY: count decrements each edge. On the edge where count==1: HI<=pend_hi, LO<=pend_lo, state goes to IDLE, E_Busy falls.
- Latency: start in cycle t gives E_Busy=1 for cycles t+1 .. t+N exactly. An MFHI reaching E in cycle t+N+1 reads the new value.
- MULT: signed 64-bit product; HI=[63:32], LO=[31:0]. MULTU: same, unsigned.
- DIV: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend. DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (signed or unsigned): the full DIV_CYCLES busy period still elapses, but HI/LO are left unchanged at commit.
- MTHI/MTLO in IDLE: HI or LO <= E_V1 at the edge, zero latency. In BUSY they are ignored; the hazard unit guarantees this cannot occur.
- MFHI/MFLO read the committed HI/LO only, never the pending values.
- MD-class instruction in E while BUSY: ignored, no restart; the hazard contract forbids it.
- Bubble (E_Instr=0): no effect in any state.
- Reset asserted mid-operation: the operation is aborted, with no commit.

Optional Feature:
- Macro MD_MADD_EN.
- Defined:
  - Adds MADD (opcode 0x1C, funct 0x00) and MADDU (opcode 0x1C, funct 0x01), counted as MD-class for E_Start.
  - pend = {HI,LO} + signed/unsigned product, modulo 2^64, computed from the HI/LO values at start.
  - Busy for MULT_CYCLES, commit rules as for MULT.
- Undefined: opcode 0x1C is ignored and E_Start stays 0 for it.

Decomposition:
- Add MULT, MULTU, DIV, DIVU, MFHI, MTHI, MFLO, MTLO funct codes and SPECIAL2 (0x1C), MADD, MADDU to constants.v.
- FSM state encodings IDLE/BUSY are local parameters, not shared.
- No sub-module; decode and arithmetic stay inline.
- The hazard unit separately ORs E_Start|E_Busy with "D instr is MD-class" to form the stall.

Test Plan:
- MULT 0xFFFFFFFF*0xFFFFFFFF:
  - E_Start=1 in the issue cycle, then E_Busy=1 for exactly 5 cycles.
  - HI=0x00000000, LO=0x00000001.
  - MFHI issued during busy then stalled reads 0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 -> E_Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTLO 0x12345678, then DIVU 7/0:
  - LO=0x12345678 the next cycle.
  - After 10 busy cycles LO is still 0x12345678 and HI=0.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Reset pulled low at cycle 3 of a DIV:
  - E_Busy=0 and HI=LO=0 immediately, without waiting for a clock.
  - Release reset, then MFLO -> 0.
  - Repeat with MD_MADD_EN: HI:LO=0:5, then MADD 3*4 -> HI=0, LO=17 after 5 cycles.

Source files
------------

// File: rtl/e_muldiv_pkg.sv
// Shared decode constants and helpers for the execute-stage multiply/divide unit.
// The SPECIAL2 multiply-accumulate ops (MADD/MADDU) are decoded only when the
// MD_MADD_EN macro is defined; otherwise opcode 0x1C decodes as "not ours".
package e_muldiv_pkg;

  localparam logic [5:0] OPC_SPECIAL  = 6'h00;
  localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_MADD  = 6'h00;
  localparam logic [5:0] FN_MADDU = 6'h01;

  typedef enum logic [3:0] {
    MD_NONE,
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MADD,
    MD_MADDU,
    MD_MFHI,
    MD_MTHI,
    MD_MFLO,
    MD_MTLO
  } md_op_e;

  // Map an E-stage instruction word to the operation this unit performs.
  function automatic md_op_e md_decode(input logic [31:0] instr);
    md_op_e op;
    op = MD_NONE;
    if (instr[31:26] == OPC_SPECIAL) begin
      case (instr[5:0])
        FN_MULT:  op = MD_MULT;
        FN_MULTU: op = MD_MULTU;
        FN_DIV:   op = MD_DIV;
        FN_DIVU:  op = MD_DIVU;
        FN_MFHI:  op = MD_MFHI;
        FN_MTHI:  op = MD_MTHI;
        FN_MFLO:  op = MD_MFLO;
        FN_MTLO:  op = MD_MTLO;
        default:  op = MD_NONE;
      endcase
    end
`ifdef MD_MADD_EN
    else if (instr[31:26] == OPC_SPECIAL2) begin
      case (instr[5:0])
        FN_MADD:  op = MD_MADD;
        FN_MADDU: op = MD_MADDU;
        default:  op = MD_NONE;
      endcase
    end
`endif
    return op;
  endfunction

  // Multi-cycle operations that occupy the unit (drive E_Start).
  function automatic logic md_is_start(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
           (op == MD_DIVU) || (op == MD_MADD)  || (op == MD_MADDU);
  endfunction

  function automatic logic md_is_mul_class(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) || (op == MD_MADDU);
  endfunction

endpackage

// File: rtl/e_muldiv.sv
// Execute-stage multiply/divide unit owning the HI/LO registers.
// The full result is computed at issue into pend_hi/pend_lo and committed to
// HI/LO after a fixed busy period, modelling a multi-cycle datapath.
// Optional MADD/MADDU support is enabled with the MD_MADD_EN macro.
module e_muldiv
  import e_muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_V1,
  input  logic [31:0] E_V2,
  input  logic [31:0] E_Instr,
  output logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_MDout
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;

  md_op_e             op;
  logic               is_signed;
  logic [63:0]        mul_a, mul_b, product, mul_res;
  logic               a_neg, b_neg;
  logic [31:0]        a_mag, b_mag, q_mag, r_mag, quot, rem;

  assign op        = md_decode(E_Instr);
  assign is_signed = (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD);

  // Product (plus HI:LO accumulate for MADD/MADDU), modulo 2^64.
  always_comb begin
    mul_a   = {{32{is_signed & E_V1[31]}}, E_V1};
    mul_b   = {{32{is_signed & E_V2[31]}}, E_V2};
    product = mul_a * mul_b;
    if ((op == MD_MADD) || (op == MD_MADDU)) begin
      mul_res = product + {hi_q, lo_q};
    end else begin
      mul_res = product;
    end
  end

  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // takes the dividend's sign; 0x80000000 / -1 wraps to 0x80000000 rem 0.
  always_comb begin
    a_neg = is_signed & E_V1[31];
    b_neg = is_signed & E_V2[31];
    a_mag = a_neg ? (~E_V1 + 32'd1) : E_V1;
    b_mag = b_neg ? (~E_V2 + 32'd1) : E_V2;
    q_mag = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
    r_mag = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
    quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem   = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  // Next-state logic: issue, countdown and commit.
  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      S_IDLE: begin
        if (op == MD_MTHI) begin
          hi_d = E_V1;
        end else if (op == MD_MTLO) begin
          lo_d = E_V1;
        end else if (md_is_mul_class(op)) begin
          pend_hi_d = mul_res[63:32];
          pend_lo_d = mul_res[31:0];
          pend_wr_d = 1'b1;
          count_d   = CNT_W'(MULT_CYCLES);
          state_d   = S_BUSY;
        end else if ((op == MD_DIV) || (op == MD_DIVU)) begin
          pend_hi_d = rem;
          pend_lo_d = quot;
          // Divide by zero still runs the full period but leaves HI/LO alone.
          pend_wr_d = (E_V2 != 32'd0);
          count_d   = CNT_W'(DIV_CYCLES);
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any in-flight operation without commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Outputs: Start/Busy to the hazard unit, committed HI/LO to the result mux.
  always_comb begin
    E_Start = (state_q == S_IDLE) && md_is_start(op);
    E_Busy  = (state_q == S_BUSY);
    case (op)
      MD_MFHI: E_MDout = hi_q;
      MD_MFLO: E_MDout = lo_q;
      default: E_MDout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_muldiv.sv
// Directed self-checking bench for e_muldiv (MULT_CYCLES=5, DIV_CYCLES=10).
// Inputs are driven and outputs sampled around the falling edge; the DUT
// acts on the rising edge. Build with MD_MADD_EN to cover MADD/MADDU.
module tb_e_muldiv;

  localparam int NM = 5;
  localparam int ND = 10;

  localparam logic [31:0] I_MULT  = 32'h0000_0018;
  localparam logic [31:0] I_MULTU = 32'h0000_0019;
  localparam logic [31:0] I_DIV   = 32'h0000_001A;
  localparam logic [31:0] I_DIVU  = 32'h0000_001B;
  localparam logic [31:0] I_MFHI  = 32'h0000_0010;
  localparam logic [31:0] I_MTHI  = 32'h0000_0011;
  localparam logic [31:0] I_MFLO  = 32'h0000_0012;
  localparam logic [31:0] I_MTLO  = 32'h0000_0013;
  localparam logic [31:0] I_MADD  = 32'h7000_0000;
  localparam logic [31:0] I_MADDU = 32'h7000_0001;

  logic        clk;
  logic        reset;
  logic [31:0] E_V1, E_V2, E_Instr;
  logic        E_Start, E_Busy;
  logic [31:0] E_MDout;

  int passed = 0;
  int total  = 0;

  e_muldiv #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk     (clk),
    .reset   (reset),
    .E_V1    (E_V1),
    .E_V2    (E_V2),
    .E_Instr (E_Instr),
    .E_Start (E_Start),
    .E_Busy  (E_Busy),
    .E_MDout (E_MDout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Read HI and LO combinationally; called and returns at a falling edge.
  task automatic read_hl(input string tag, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    E_Instr = I_MFHI;
    #1 check({tag, " MFHI"}, E_MDout, hi_exp);
    E_Instr = I_MFLO;
    #1 check({tag, " MFLO"}, E_MDout, lo_exp);
    E_Instr = 32'd0;
    @(negedge clk);
  endtask

  // Zero-latency move to HI/LO.
  task automatic move_to(input logic [31:0] instr, input logic [31:0] v);
    E_Instr = instr;
    E_V1    = v;
    #1 check("mt start", {31'd0, E_Start}, 32'd0);
    @(negedge clk);
    E_Instr = 32'd0;
    E_V1    = 32'd0;
  endtask

  // Issue a multi-cycle op and verify busy lasts exactly n cycles; during
  // busy an MFLO must still see the committed value lo_old.
  task automatic start_op(input string tag, input logic [31:0] instr, input logic [31:0] v1,
                          input logic [31:0] v2, input int n, input logic [31:0] lo_old);
    E_Instr = instr;
    E_V1    = v1;
    E_V2    = v2;
    #1 check({tag, " start"}, {31'd0, E_Start}, 32'd1);
    check({tag, " busy@issue"}, {31'd0, E_Busy}, 32'd0);
    @(negedge clk);
    E_Instr = I_MFLO;
    E_V1    = 32'd0;
    E_V2    = 32'd0;
    for (int i = 0; i < n; i++) begin
      #1 check({tag, " busy"}, {31'd0, E_Busy}, 32'd1);
      check({tag, " old LO"}, E_MDout, lo_old);
      if (i == 0) check({tag, " no start"}, {31'd0, E_Start}, 32'd0);
      @(negedge clk);
    end
    E_Instr = 32'd0;
    #1 check({tag, " busy end"}, {31'd0, E_Busy}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    E_V1    = 32'd0;
    E_V2    = 32'd0;
    E_Instr = 32'd0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, E_Busy}, 32'd0);
    check("reset start", {31'd0, E_Start}, 32'd0);
    reset = 1'b1;
    read_hl("reset", 32'h0, 32'h0);

    // Signed and unsigned multiply of all-ones operands.
    start_op("MULT", I_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NM, 32'h0);
    read_hl("MULT", 32'h0000_0000, 32'h0000_0001);
    start_op("MULTU", I_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NM, 32'h1);
    read_hl("MULTU", 32'hFFFF_FFFE, 32'h0000_0001);

    // Signed divides: -7/2 and 9/-2.
    start_op("DIV -7/2", I_DIV, 32'hFFFF_FFF9, 32'h2, ND, 32'h1);
    read_hl("DIV -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    start_op("DIV 9/-2", I_DIV, 32'h9, 32'hFFFF_FFFE, ND, 32'hFFFF_FFFD);
    read_hl("DIV 9/-2", 32'h0000_0001, 32'hFFFF_FFFC);

    // Moves, then divide by zero leaves HI/LO unchanged.
    move_to(I_MTHI, 32'h0);
    move_to(I_MTLO, 32'h1234_5678);
    read_hl("MTLO", 32'h0, 32'h1234_5678);
    start_op("DIVU 7/0", I_DIVU, 32'h7, 32'h0, ND, 32'h1234_5678);
    read_hl("DIVU 7/0", 32'h0, 32'h1234_5678);
    move_to(I_MTHI, 32'hA5A5_A5A5);
    start_op("DIV 5/0", I_DIV, 32'h5, 32'h0, ND, 32'h1234_5678);
    read_hl("DIV 5/0", 32'hA5A5_A5A5, 32'h1234_5678);

    // Overflow case of signed divide.
    start_op("DIV ovf", I_DIV, 32'h8000_0000, 32'hFFFF_FFFF, ND, 32'h1234_5678);
    read_hl("DIV ovf", 32'h0, 32'h8000_0000);

    // Reset in the third busy cycle of a DIV: immediate clear, no commit.
    move_to(I_MTHI, 32'h0000_0055);
    E_Instr = I_DIV;
    E_V1    = 32'd100;
    E_V2    = 32'd7;
    #1 check("abort start", {31'd0, E_Start}, 32'd1);
    @(negedge clk);
    E_Instr = I_MFLO;
    E_V1    = 32'd0;
    E_V2    = 32'd0;
    repeat (2) @(negedge clk);
    #1 check("abort busy pre", {31'd0, E_Busy}, 32'd1);
    reset = 1'b0;
    #1 check("abort busy", {31'd0, E_Busy}, 32'd0);
    check("abort LO", E_MDout, 32'h0);
    E_Instr = I_MFHI;
    #1 check("abort HI", E_MDout, 32'h0);
    E_Instr = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (ND + 2) @(negedge clk);
    check("post-abort busy", {31'd0, E_Busy}, 32'd0);
    read_hl("post-abort", 32'h0, 32'h0);

    move_to(I_MTLO, 32'h5);
`ifdef MD_MADD_EN
    start_op("MADD", I_MADD, 32'd3, 32'd4, NM, 32'h5);
    read_hl("MADD", 32'h0, 32'h0000_0011);
    start_op("MADDU", I_MADDU, 32'hFFFF_FFFF, 32'h2, NM, 32'h11);
    read_hl("MADDU", 32'h2, 32'h0000_000F);
`else
    E_Instr = I_MADD;
    E_V1    = 32'd3;
    E_V2    = 32'd4;
    #1 check("SPECIAL2 start", {31'd0, E_Start}, 32'd0);
    @(negedge clk);
    E_Instr = 32'd0;
    #1 check("SPECIAL2 busy", {31'd0, E_Busy}, 32'd0);
    @(negedge clk);
    read_hl("SPECIAL2", 32'h0, 32'h5);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
